tmds_encoder: RTL and testbench



---
 rtl/tmds_encoder.sv | 108 ++++++++++
 tb/tb_tmds_encoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// Per-channel DVI/HDMI TMDS 8b/10b encoder: two-stage pipeline turning video data
// or control bits into a DC-balanced 10-bit symbol (bit 0 transmitted first).
module tmds_encoder #(
  parameter int DISPARITY_WIDTH = 5
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       dataEnable,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  output logic [9:0] symbol
);

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef logic signed [DISPARITY_WIDTH-1:0] disp_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  logic [3:0] dataOnes;
  logic       useXnor;
  logic [8:0] qm_d;
  logic [8:0] qm_q;
  logic       dataEnable_q;
  logic [1:0] ctrl_q;

  // Stage 1: transition-minimising XOR/XNOR chain
  always_comb begin
    dataOnes = popcount8(data);
    useXnor  = (dataOnes > 4'd4) || ((dataOnes == 4'd4) && !data[0]);
    qm_d     = '0;
    qm_d[0]  = data[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = useXnor ? ~(qm_d[i-1] ^ data[i]) : (qm_d[i-1] ^ data[i]);
    end
    qm_d[8] = ~useXnor;
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      qm_q         <= '0;
      dataEnable_q <= 1'b0;
      ctrl_q       <= 2'b00;
    end else begin
      qm_q         <= qm_d;
      dataEnable_q <= dataEnable;
      ctrl_q       <= ctrl;
    end
  end

  logic [3:0] qmOnes;
  disp_t      balance;
  disp_t      twoQm8;
  disp_t      twoNotQm8;
  disp_t      cnt_d;
  disp_t      cnt_q;
  logic [9:0] symbol_d;
  logic [9:0] symbol_q;

  // Stage 2: DC balancing; balance is n1q - n0q = 2*n1q - 8
  always_comb begin
    qmOnes    = popcount8(qm_q[7:0]);
    balance   = disp_t'({qmOnes, 1'b0}) - disp_t'(8);
    twoQm8    = disp_t'({qm_q[8], 1'b0});
    twoNotQm8 = disp_t'({~qm_q[8], 1'b0});
    symbol_d  = symbol_q;
    cnt_d     = cnt_q;
    if (!dataEnable_q) begin
      cnt_d = '0;
      case (ctrl_q)
        2'b00:   symbol_d = CTRL_TOKEN_00;
        2'b01:   symbol_d = CTRL_TOKEN_01;
        2'b10:   symbol_d = CTRL_TOKEN_10;
        default: symbol_d = CTRL_TOKEN_11;
      endcase
    end else if ((cnt_q == 0) || (qmOnes == 4'd4)) begin
      symbol_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d    = qm_q[8] ? (cnt_q + balance) : (cnt_q - balance);
    end else if (((cnt_q > 0) && (qmOnes > 4'd4)) || ((cnt_q < 0) && (qmOnes < 4'd4))) begin
      symbol_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d    = cnt_q + twoQm8 - balance;
    end else begin
      symbol_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d    = cnt_q + balance - twoNotQm8;
    end
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      symbol_q <= CTRL_TOKEN_00;
      cnt_q    <= '0;
    end else begin
      symbol_q <= symbol_d;
      cnt_q    <= cnt_d;
    end
  end

  assign symbol = symbol_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed token/disparity cases plus a long
// randomized run compared against a behavioural TMDS reference model.
module tb_tmds_encoder;

  logic       pixelClock;
  logic       resetN;
  logic       dataEnable;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic [9:0] symbol;

  int testsRun    = 0;
  int testsFailed = 0;

  int         modelCnt;
  logic [9:0] expQ[$];
  logic [9:0] obsLog[$];
  logic [9:0] ctrlTok[4];

  tmds_encoder #(.DISPARITY_WIDTH(5)) dut (
    .pixelClock(pixelClock),
    .resetN    (resetN),
    .dataEnable(dataEnable),
    .data      (data),
    .ctrl      (ctrl),
    .symbol    (symbol)
  );

  initial pixelClock = 1'b0;
  always #5 pixelClock = ~pixelClock;

  task automatic checkOutput(input string tag, input logic [9:0] actual, input logic [9:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference TMDS encoding straight from the rules, with the running disparity kept as an int
  function automatic logic [9:0] modelEncode(input logic de, input logic [7:0] d, input logic [1:0] c);
    int         ones;
    int         onesQ;
    int         diff;
    bit         invertChain;
    bit         q8;
    logic [7:0] qm;
    logic [9:0] sym;
    if (!de) begin
      modelCnt = 0;
      return ctrlTok[c];
    end
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    invertChain = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = invertChain ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = !invertChain;
    onesQ = 0;
    for (int i = 0; i < 8; i++) onesQ += int'(qm[i]);
    diff = onesQ - (8 - onesQ);
    if (modelCnt == 0 || diff == 0) begin
      sym = {~q8, q8, q8 ? qm : ~qm};
      modelCnt += q8 ? diff : -diff;
    end else if ((modelCnt > 0 && diff > 0) || (modelCnt < 0 && diff < 0)) begin
      sym = {1'b1, q8, ~qm};
      modelCnt += 2 * int'(q8) - diff;
    end else begin
      sym = {1'b0, q8, qm};
      modelCnt += diff - 2 * int'(!q8);
    end
    return sym;
  endfunction

  task automatic resetModel();
    modelCnt = 0;
    expQ.delete();
    expQ.push_back(10'h354);
    expQ.push_back(10'h354);
  endtask

  // Drive one input word, clock it, and compare the symbol now leaving the pipeline
  task automatic applyStimulus(input string tag, input logic de, input logic [7:0] d, input logic [1:0] c);
    dataEnable = de;
    data       = d;
    ctrl       = c;
    expQ.push_back(modelEncode(de, d, c));
    @(posedge pixelClock);
    #1;
    void'(expQ.pop_front());
    checkOutput(tag, symbol, expQ[0]);
    obsLog.push_back(symbol);
  endtask

  initial begin
    int base;
    int words;
    int burst;
    int blank;
    ctrlTok[0] = 10'h354;
    ctrlTok[1] = 10'h0AB;
    ctrlTok[2] = 10'h154;
    ctrlTok[3] = 10'h2AB;
    resetN     = 1'b0;
    dataEnable = 1'b0;
    data       = 8'h00;
    ctrl       = 2'b00;

    // Reset held while inputs wiggle across clock edges
    for (int i = 0; i < 4; i++) begin
      @(posedge pixelClock);
      #1;
      dataEnable = 1'($urandom);
      data       = 8'($urandom);
      ctrl       = 2'($urandom);
      #2;
      checkOutput("rstHold", symbol, 10'h354);
    end
    @(negedge pixelClock);
    dataEnable = 1'b0;
    data       = 8'h00;
    ctrl       = 2'b00;
    resetN     = 1'b1;
    resetModel();
    applyStimulus("rstRelease", 1'b0, 8'h00, 2'b00);
    applyStimulus("rstRelease", 1'b0, 8'h00, 2'b00);

    // Control tokens, each two cycles after its input
    base = obsLog.size();
    for (int k = 0; k < 4; k++) applyStimulus("ctrlSeq", 1'b0, 8'($urandom), 2'(k));
    applyStimulus("ctrlSeq", 1'b0, 8'h00, 2'b00);
    for (int k = 0; k < 4; k++) checkOutput("ctrlTok", obsLog[base + k + 1], ctrlTok[k]);

    // Disparity walk on all-zero data
    base = obsLog.size();
    for (int k = 0; k < 3; k++) applyStimulus("walkSeq", 1'b1, 8'h00, 2'b00);
    applyStimulus("walkSeq", 1'b0, 8'h00, 2'b00);
    applyStimulus("walkSeq", 1'b0, 8'h00, 2'b00);
    checkOutput("walk0", obsLog[base + 1], 10'h100);
    checkOutput("walk1", obsLog[base + 2], 10'h3FF);
    checkOutput("walk2", obsLog[base + 3], 10'h100);
    checkOutput("walkCtrl", obsLog[base + 4], 10'h354);

    // XNOR path and a balanced word, each starting from zero disparity
    base = obsLog.size();
    applyStimulus("xnorSeq", 1'b1, 8'hFF, 2'b00);
    applyStimulus("xnorSeq", 1'b0, 8'h00, 2'b01);
    applyStimulus("xnorSeq", 1'b1, 8'h10, 2'b00);
    applyStimulus("xnorSeq", 1'b0, 8'h00, 2'b00);
    applyStimulus("xnorSeq", 1'b0, 8'h00, 2'b00);
    checkOutput("xnorFF", obsLog[base + 1], 10'h200);
    checkOutput("afterFF", obsLog[base + 2], 10'h0AB);
    checkOutput("bal10", obsLog[base + 3], 10'h1F0);

    // Long randomized run with periodic blanking
    words = 0;
    while (words < 10000) begin
      burst = int'($urandom_range(16, 160));
      for (int k = 0; k < burst; k++) begin
        applyStimulus("randData", 1'b1, 8'($urandom), 2'($urandom));
        words++;
      end
      blank = int'($urandom_range(1, 5));
      for (int k = 0; k < blank; k++) applyStimulus("randBlank", 1'b0, 8'($urandom), 2'($urandom));
    end

    // Asynchronous reset pulse in the middle of a data burst
    applyStimulus("preRst", 1'b0, 8'h00, 2'b00);
    for (int k = 0; k < 6; k++) applyStimulus("preRst", 1'b1, 8'($urandom), 2'b00);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("asyncRst", symbol, 10'h354);
    #2;
    resetN = 1'b1;
    resetModel();
    base = obsLog.size();
    applyStimulus("postRst", 1'b1, 8'h00, 2'b00);
    applyStimulus("postRst", 1'b1, 8'h00, 2'b00);
    applyStimulus("postRst", 1'b0, 8'h00, 2'b00);
    applyStimulus("postRst", 1'b0, 8'h00, 2'b00);
    checkOutput("rstFlush", obsLog[base], 10'h354);
    checkOutput("rstFirst", obsLog[base + 1], 10'h100);
    checkOutput("rstSecond", obsLog[base + 2], 10'h3FF);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
